// File: rtl/fetch_unit_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int DEFAULT_INSTR_W = 48;
  localparam int DEFAULT_ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; push is accepted when full if a pop happens on the same edge.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order memory requests, pairs responses with their PCs,
// buffers them for the F/D register, and discards in-flight responses after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                INSTR_W  = DEFAULT_INSTR_W,
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               StallF,
  input  logic               BranchE,
  input  logic [ADDR_W-1:0]  PCTargetE,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic [INSTR_W-1:0] InstrF,
  output logic [ADDR_W-1:0]  PCF,
  output logic               ValidF
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_t       state, state_next;
  logic [ADDR_W-1:0]  pc, pc_next;
  logic [CNT_W-1:0]   outstanding, outstanding_next;
  logic [CNT_W-1:0]   drop_cnt, drop_cnt_next;
  logic [CNT_W-1:0]   buf_count;
  logic [CNT_W-1:0]   tag_count;
  logic [ADDR_W-1:0]  tag_head;
  logic [ENTRY_W-1:0] buf_head;
  logic [CNT_W:0]     credit;
  logic               req_fire;
  logic               resp_fire;
  logic               resp_keep;
  logic               pop_now;

  assign ValidF  = (buf_count != '0);
  assign PCF     = ValidF ? buf_head[ENTRY_W-1 -: ADDR_W] : '0;
  assign InstrF  = ValidF ? buf_head[INSTR_W-1:0] : '0;
  assign pop_now = ValidF && !StallF && !BranchE;

  // The slot freed by this edge's pop counts as free, so one instruction per cycle is sustained at DEPTH=2.
  assign credit         = {1'b0, tag_count} + {1'b0, buf_count} - (CNT_W + 1)'(pop_now);
  assign imem_req_valid = (state == FETCH) && (credit < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_fire      = imem_resp_valid && (outstanding != '0);
  assign resp_keep      = resp_fire && (state == FETCH) && !BranchE && (tag_count != '0);

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
    .clk   (CLK),
    .rst_n (RST_N),
    .flush (BranchE),
    .push  (req_fire),
    .din   (pc),
    .pop   (resp_keep),
    .head  (tag_head),
    .count (tag_count)
  );

  fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_instr_buf (
    .clk   (CLK),
    .rst_n (RST_N),
    .flush (BranchE),
    .push  (resp_keep),
    .din   ({tag_head, imem_resp_data}),
    .pop   (pop_now),
    .head  (buf_head),
    .count (buf_count)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    drop_cnt_next    = drop_cnt;
    outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(resp_fire);
    if (req_fire) pc_next = pc + ADDR_W'(1);

    case (state)
      IDLE:  state_next = FETCH;
      FETCH: state_next = FETCH;
      FLUSH: begin
        if (resp_fire) drop_cnt_next = drop_cnt - CNT_W'(1);
        if (drop_cnt_next == '0) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase

    // Everything still in flight after this edge belongs to the old path.
    if (BranchE) begin
      pc_next       = PCTargetE;
      drop_cnt_next = outstanding_next;
      state_next    = (outstanding_next != '0) ? FLUSH : FETCH;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order 1-cycle memory model plus a PC/instruction scoreboard.
module tb_fetch_unit;

  localparam int INSTR_W = 48;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b1;
  logic               StallF = 1'b0;
  logic               BranchE = 1'b0;
  logic [ADDR_W-1:0]  PCTargetE = '0;
  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready = 1'b1;
  logic               imem_resp_valid = 1'b0;
  logic [INSTR_W-1:0] imem_resp_data = '0;
  logic [INSTR_W-1:0] InstrF;
  logic [ADDR_W-1:0]  PCF;
  logic               ValidF;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] mem_q[$];
  logic [ADDR_W-1:0] sb_pc;
  logic [ADDR_W-1:0] m_req_addr;
  bit                m_req_fire = 1'b0;
  bit                m_resp_fire = 1'b0;
  bit                mem_hold = 1'b0;
  int                max_out = 0;

  fetch_unit #(
    .INSTR_W  (INSTR_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .StallF          (StallF),
    .BranchE         (BranchE),
    .PCTargetE       (PCTargetE),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .InstrF          (InstrF),
    .PCF             (PCF),
    .ValidF          (ValidF)
  );

  always #5 CLK = ~CLK;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a};
  endfunction

  task automatic load_expected(input logic [ADDR_W-1:0] start);
    logic [ADDR_W-1:0] a;
    a = start;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(a);
      a = a + 32'd1;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ValidF) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Handshakes are sampled mid-cycle and applied just after the next rising edge.
  always @(negedge CLK) begin
    m_req_fire  = RST_N && imem_req_valid && imem_req_ready;
    m_req_addr  = imem_req_addr;
    m_resp_fire = RST_N && imem_resp_valid;
  end

  always @(posedge CLK) begin
    #1;
    if (!RST_N) begin
      mem_q.delete();
    end else begin
      if (m_resp_fire && mem_q.size() > 0) void'(mem_q.pop_front());
      if (m_req_fire) mem_q.push_back(m_req_addr);
    end
    m_req_fire  = 1'b0;
    m_resp_fire = 1'b0;
    imem_resp_valid = RST_N && !mem_hold && (mem_q.size() > 0);
    imem_resp_data  = imem_resp_valid ? mem_word(mem_q[0]) : '0;
  end

  always @(negedge CLK) begin
    if (RST_N && ValidF && !StallF && !BranchE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_order: consumed pc=%h but nothing expected", PCF);
      end else begin
        sb_pc = exp_q.pop_front();
        if (PCF !== sb_pc || InstrF !== mem_word(sb_pc)) begin
          errors++;
          $display("FAIL sb_instr: got pc=%h instr=%h, expected pc=%h instr=%h",
                   PCF, InstrF, sb_pc, mem_word(sb_pc));
        end
      end
    end
    if (mem_q.size() > max_out) max_out = mem_q.size();
  end

  task automatic test_reset();
    #1;
    RST_N = 1'b0;
    load_expected(RESET_PC);
    #1;
    checks++;
    if (ValidF !== 1'b0 || PCF !== '0 || InstrF !== '0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b pc=%h instr=%h req=%b, expected all zero",
               ValidF, PCF, InstrF, imem_req_valid);
    end
    step();
    step();
    checks++;
    if (ValidF !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: valid=%b req=%b, expected 0 0", ValidF, imem_req_valid);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_latency();
    step();
    checks++;
    if (ValidF !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL lat_edge1: valid=%b req=%b addr=%h, expected 0 1 %h",
               ValidF, imem_req_valid, imem_req_addr, RESET_PC);
    end
    step();
    checks++;
    if (ValidF !== 1'b0) begin
      errors++;
      $display("FAIL lat_edge2: valid=%b, expected 0", ValidF);
    end
    step();
    checks++;
    if (ValidF !== 1'b1 || PCF !== RESET_PC) begin
      errors++;
      $display("FAIL lat_edge3: valid=%b pc=%h, expected 1 %h", ValidF, PCF, RESET_PC);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (ValidF !== 1'b1 || PCF !== RESET_PC + 32'(i)) begin
        errors++;
        $display("FAIL lat_stream: valid=%b pc=%h, expected 1 %h", ValidF, PCF, RESET_PC + 32'(i));
      end
    end
  endtask

  task automatic test_stall();
    bit found;
    logic [INSTR_W-1:0] held;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ValidF && PCF == 32'd5) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stall_reach: pc=%h, expected to reach 00000005", PCF);
    end
    StallF = 1'b1;
    held = mem_word(32'd5);
    max_out = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ValidF !== 1'b1 || PCF !== 32'd5 || InstrF !== held) begin
        errors++;
        $display("FAIL stall_hold: valid=%b pc=%h instr=%h, expected 1 00000005 %h",
                 ValidF, PCF, InstrF, held);
      end
    end
    checks++;
    if (imem_req_valid !== 1'b0 || max_out > DEPTH) begin
      errors++;
      $display("FAIL stall_credit: req=%b max_out=%0d, expected 0 and <=%0d",
               imem_req_valid, max_out, DEPTH);
    end
    StallF = 1'b0;
    step();
    checks++;
    if (ValidF !== 1'b1 || PCF !== 32'd6) begin
      errors++;
      $display("FAIL stall_resume: valid=%b pc=%h, expected 1 00000006", ValidF, PCF);
    end
  endtask

  task automatic test_branch();
    bit ok;
    mem_hold = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (mem_q.size() != 2 || ValidF !== 1'b0) begin
      errors++;
      $display("FAIL br_setup: outstanding=%0d valid=%b, expected 2 0", mem_q.size(), ValidF);
    end
    BranchE = 1'b1;
    PCTargetE = 32'h0000_0040;
    load_expected(32'h0000_0040);
    step();
    BranchE = 1'b0;
    mem_hold = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_flush_noreq: req=%b, expected 0", imem_req_valid);
    end
    wait_valid(20, ok);
    checks++;
    if (!ok || PCF !== 32'h0000_0040) begin
      errors++;
      $display("FAIL br_target: valid=%b pc=%h, expected 1 00000040", ValidF, PCF);
    end
  endtask

  task automatic test_branch_resp_stall();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_resp_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL brs_setup: resp_valid=%b, expected a response", imem_resp_valid);
    end
    StallF = 1'b1;
    BranchE = 1'b1;
    PCTargetE = 32'h0000_0080;
    load_expected(32'h0000_0080);
    step();
    checks++;
    if (ValidF !== 1'b0 || PCF !== '0 || InstrF !== '0) begin
      errors++;
      $display("FAIL brs_empty: valid=%b pc=%h instr=%h, expected 0 0 0", ValidF, PCF, InstrF);
    end
    BranchE = 1'b0;
    StallF = 1'b0;
    wait_valid(20, ok);
    checks++;
    if (!ok || PCF !== 32'h0000_0080) begin
      errors++;
      $display("FAIL brs_target: valid=%b pc=%h, expected 1 00000080", ValidF, PCF);
    end
  endtask

  task automatic test_pc_wrap();
    bit ok;
    BranchE = 1'b1;
    PCTargetE = 32'hFFFF_FFFF;
    load_expected(32'hFFFF_FFFF);
    step();
    BranchE = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid && imem_req_addr == 32'hFFFF_FFFF) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    checks++;
    if (!ok || imem_req_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_addr: seen=%b addr=%h, expected 1 00000000", ok, imem_req_addr);
    end
    wait_valid(20, ok);
    checks++;
    if (!ok || PCF !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_pcf: valid=%b pc=%h, expected 1 ffffffff", ValidF, PCF);
    end
    step();
    checks++;
    if (ValidF !== 1'b1 || PCF !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_next: valid=%b pc=%h, expected 1 00000000", ValidF, PCF);
    end
  endtask

  task automatic test_reset_async();
    bit ok;
    StallF = 1'b1;
    step();
    step();
    checks++;
    if (ValidF !== 1'b1) begin
      errors++;
      $display("FAIL rsta_pre: valid=%b, expected 1", ValidF);
    end
    #1;
    RST_N = 1'b0;
    load_expected(RESET_PC);
    #1;
    checks++;
    if (ValidF !== 1'b0 || PCF !== '0 || InstrF !== '0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsta_zero: valid=%b pc=%h instr=%h req=%b, expected all zero",
               ValidF, PCF, InstrF, imem_req_valid);
    end
    StallF = 1'b0;
    step();
    step();
    RST_N = 1'b1;
    wait_valid(10, ok);
    checks++;
    if (!ok || PCF !== RESET_PC) begin
      errors++;
      $display("FAIL rsta_restart: valid=%b pc=%h, expected 1 %h", ValidF, PCF, RESET_PC);
    end
  endtask

  task automatic test_reset_mid_flush();
    mem_hold = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (mem_q.size() != 2) begin
      errors++;
      $display("FAIL rstf_setup: outstanding=%0d, expected 2", mem_q.size());
    end
    BranchE = 1'b1;
    PCTargetE = 32'h0000_0100;
    load_expected(32'h0000_0100);
    step();
    BranchE = 1'b0;
    step();
    checks++;
    if (imem_req_valid !== 1'b0 || ValidF !== 1'b0) begin
      errors++;
      $display("FAIL rstf_in_flush: req=%b valid=%b, expected 0 0", imem_req_valid, ValidF);
    end
    #1;
    RST_N = 1'b0;
    load_expected(RESET_PC);
    #1;
    checks++;
    if (ValidF !== 1'b0 || PCF !== '0 || InstrF !== '0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstf_zero: valid=%b pc=%h instr=%h req=%b, expected all zero",
               ValidF, PCF, InstrF, imem_req_valid);
    end
    mem_hold = 1'b0;
    step();
    step();
    RST_N = 1'b1;
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rstf_restart_req: req=%b addr=%h, expected 1 %h",
               imem_req_valid, imem_req_addr, RESET_PC);
    end
    step();
    step();
    checks++;
    if (ValidF !== 1'b1 || PCF !== RESET_PC) begin
      errors++;
      $display("FAIL rstf_restart: valid=%b pc=%h, expected 1 %h", ValidF, PCF, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_branch();
    test_branch_resp_stall();
    test_pc_wrap();
    test_reset_async();
    test_reset_mid_flush();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports CLK and RST_N.
REQ-002 Parameter INSTR_W, default 48: instruction width in bits.
REQ-003 Parameter ADDR_W, default 32: PC width, word-addressed (one instruction per address).
REQ-004 Parameter DEPTH, default 2: instruction-buffer entries, also the maximum number of outstanding memory requests.
REQ-005 Parameter RESET_PC, default 0: first fetch address.
REQ-006 CLK  in  1  rising-edge clock.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 StallF  in  1  hazard-unit stall: hold the current output.
REQ-009 BranchE  in  1  redirect request from execute.
REQ-010 PCTargetE  in  ADDR_W  redirect target.
REQ-011 imem_req_valid  out  1  request valid.
REQ-012 imem_req_addr  out  ADDR_W  request address.
REQ-013 imem_req_ready  in  1  memory accepts the request.
REQ-014 imem_resp_valid  in  1  response valid; responses return in order, any latency >= 1 cycle.
REQ-015 imem_resp_data  in  INSTR_W  returned instruction.
REQ-016 InstrF  out  INSTR_W  instruction presented to the F/D register.
REQ-017 PCF  out  ADDR_W  PC of InstrF.
REQ-018 ValidF  out  1  InstrF holds a real instruction; 0 means bubble.

Function
REQ-019 A request SHALL transfer when imem_req_valid and imem_req_ready are both 1 on a rising edge; fetch PC then increments by 1 and wraps at 2^ADDR_W.
REQ-020 imem_req_valid SHALL be 1 only in FETCH while outstanding + buffer occupancy < DEPTH; imem_req_addr SHALL equal the fetch PC.
REQ-021 Each accepted request's PC SHALL enter an in-order tag queue; each response SHALL pair with the head tag and push {PC, data} into the instruction buffer in the same edge.
REQ-022 With the buffer non-empty, outputs SHALL show the head entry with ValidF=1; when empty, InstrF=0, PCF=0, ValidF=0.
REQ-023 The head SHALL pop on an edge where ValidF=1 and StallF=0; while StallF=1 the outputs SHALL stay unchanged.
REQ-024 Push and pop in the same cycle SHALL be allowed at any occupancy, including full.
REQ-025 States: IDLE (one cycle after reset) -> FETCH; FETCH with BranchE=1 -> FLUSH when responses are outstanding, else stays in FETCH; FLUSH -> FETCH when the drop counter reaches 0.
REQ-026 On BranchE=1, next edge: fetch PC <= PCTargetE, buffer cleared, drop counter <= outstanding count (minus 1 if a response arrives that same edge).
REQ-027 A response arriving in the same cycle as BranchE=1 SHALL be discarded.
REQ-028 A request accepted in the same cycle as BranchE=1 SHALL be counted for dropping.
REQ-029 In FLUSH, no requests SHALL issue; each response SHALL decrement the drop counter and be discarded.
REQ-030 BranchE SHALL take priority over StallF.
REQ-031 BranchE in FLUSH SHALL reload the target and keep dropping outstanding responses.
REQ-032 Latency: with a 1-cycle memory and no stall, the first instruction SHALL reach ValidF=1 three edges after reset release; after that, throughput SHALL be one instruction per cycle.

Reset
REQ-033 RST_N low SHALL immediately force: state IDLE, fetch PC=RESET_PC, buffer and tag queue empty, outstanding and drop counters 0, imem_req_valid=0, InstrF=0, PCF=0, ValidF=0.
REQ-034 Reset mid-operation SHALL abandon in-flight requests; the memory is reset with the same RST_N.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE, FETCH, FLUSH) and the default widths INSTR_W and ADDR_W.
REQ-036 The instruction buffer and the tag queue SHALL be instances of one sub-module, fetch_fifo, a parameterised synchronous FIFO with a flush input.

Verification
REQ-037 Reset release, 1-cycle memory, no stall -> ValidF=1 at edge 3 with PCF=0, then PCF 1,2,3 on consecutive cycles.
REQ-038 StallF=1 for 4 cycles while PCF=5 -> PCF=5 and InstrF held; with DEPTH=2, at most 2 requests outstanding; resumes at PCF=6.
REQ-039 BranchE=1, PCTargetE=0x40, 2 responses outstanding -> both discarded, next ValidF=1 has PCF=0x40.
REQ-040 BranchE=1 in the same cycle as a response with StallF=1 -> response dropped, buffer empty, ValidF=0 next cycle.
REQ-041 Fetch PC=0xFFFFFFFF -> next request address 0x00000000.
REQ-042 RST_N asserted mid-FLUSH -> all outputs zero immediately; after release, fetch restarts at RESET_PC.
